prod_bcd_conv: RTL and testbench

//  Downstream of the 8x8 signed multiplier. Captures the 16-bit two's-complement product {Aval,Bval}
//  on a Start pulse and converts it to sign + 5 BCD digits with a sequential double-dabble engine.

---
 rtl/prod_bcd_conv.sv | 112 +++++++++++
 tb/tb_prod_bcd_conv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/prod_bcd_conv.sv
// Signed product to sign + BCD converter: captures {Aval,Bval} on Start and runs a
// sequential double-dabble, one shift per clock, holding the result until the next conversion.
module prod_bcd_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH/2-1:0]    Aval,
   input  logic [WIDTH/2-1:0]    Bval,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Neg,
   output logic [4*DIGITS-1:0]   Digits
);

   localparam int CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_sign;
   logic [WIDTH-1:0]      r_bin;
   logic [4*DIGITS-1:0]   r_bcd;
   logic [CNTW-1:0]       r_cnt;
   logic [4*DIGITS-1:0]   r_digits;
   logic                  r_neg;
   logic                  r_done;

   logic [WIDTH-1:0]      w_prod;
   logic [WIDTH-1:0]      w_mag;
   logic [4*DIGITS-1:0]   w_adj;
   logic                  w_lastShift;

   assign w_prod      = {Aval, Bval};
   assign w_mag       = w_prod[WIDTH-1] ? (~w_prod + WIDTH'(1)) : w_prod;
   assign w_lastShift = (r_cnt == CNTW'(WIDTH - 1));

   // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (Start) w_nextState = CONVERT;
         CONVERT: if (w_lastShift) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath: the working registers are private, so outputs only change in DONE.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_sign   <= 1'b0;
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_digits <= '0;
         r_neg    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_sign <= w_prod[WIDTH-1];
                  r_bin  <= w_mag;
                  r_bcd  <= '0;
                  r_cnt  <= '0;
               end
            end
            CONVERT: begin
               {r_bcd, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
               r_cnt          <= r_cnt + CNTW'(1);
            end
            DONE: begin
               r_digits <= r_bcd;
               r_neg    <= r_sign;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Busy   = (r_state != IDLE);
   assign Done   = r_done;
   assign Neg    = r_neg;
   assign Digits = r_digits;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv: hand-computed BCD results, latency, busy length,
// Start filtering, async reset abort and back-to-back acceptance.
module tb_prod_bcd_conv;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [7:0]  Aval;
   logic [7:0]  Bval;
   logic        Busy;
   logic        Done;
   logic        Neg;
   logic [19:0] Digits;

   int checks = 0;
   int errors = 0;
   int lat;
   int busyN;
   int doneCount;

   prod_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .Aval   (Aval),
      .Bval   (Bval),
      .Busy   (Busy),
      .Done   (Done),
      .Neg    (Neg),
      .Digits (Digits)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive a product and pulse Start across one rising edge; returns #1 after that edge.
   task automatic applyStimulus(input logic [15:0] prod);
      {Aval, Bval} = prod;
      Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
   endtask

   // Count edges until Done, optionally re-poking Start/operands at edge pokeAt.
   task automatic waitDone(input int pokeAt, input logic [15:0] pokeVal,
                           output int latency, output int busyCycles);
      int n;
      n = 0;
      busyCycles = Busy ? 1 : 0;
      latency = -1;
      while (n < 40) begin
         @(posedge Clk);
         n++;
         #1;
         if (n == pokeAt) begin
            {Aval, Bval} = pokeVal;
            Start = 1'b1;
         end else if (n == pokeAt + 1) begin
            Start = 1'b0;
         end
         if (Done) begin
            latency = n;
            break;
         end
         if (Busy) busyCycles++;
      end
      if (latency < 0) checkOutput("done_timeout", 32'(n), 32'd17);
   endtask

   task automatic convert(input string tag, input logic [15:0] prod,
                          input logic expNeg, input logic [19:0] expDigits);
      applyStimulus(prod);
      waitDone(0, 16'h0, lat, busyN);
      checkOutput({tag, "_lat"}, 32'(lat), 32'd17);
      checkOutput({tag, "_neg"}, 32'(Neg), 32'(expNeg));
      checkOutput({tag, "_digits"}, 32'(Digits), 32'(expDigits));
   endtask

   initial begin
      Reset = 1'b0;
      Start = 1'b0;
      Aval  = 8'h00;
      Bval  = 8'h00;
      #23;
      checkOutput("reset_busy", 32'(Busy), 32'd0);
      checkOutput("reset_done", 32'(Done), 32'd0);
      checkOutput("reset_neg", 32'(Neg), 32'd0);
      checkOutput("reset_digits", 32'(Digits), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);

      // Test 1: 21, plus latency and busy length
      applyStimulus(16'h0015);
      checkOutput("t1_busy_after_start", 32'(Busy), 32'd1);
      waitDone(0, 16'h0, lat, busyN);
      checkOutput("t1_lat", 32'(lat), 32'd17);
      checkOutput("t1_busy_cycles", 32'(busyN), 32'd17);
      checkOutput("t1_busy_in_done", 32'(Busy), 32'd0);
      checkOutput("t1_neg", 32'(Neg), 32'd0);
      checkOutput("t1_digits", 32'(Digits), 32'h00021);
      @(posedge Clk);
      #1 checkOutput("t1_done_pulse_width", 32'(Done), 32'd0);
      checkOutput("t1_digits_hold", 32'(Digits), 32'h00021);

      // Tests 2 and 3: signs and magnitude extremes
      convert("t2a", 16'hFFFF, 1'b1, 20'h00001);
      convert("t2b", 16'h4000, 1'b0, 20'h16384);
      convert("t3a", 16'h8000, 1'b1, 20'h32768);
      convert("t3b", 16'hC080, 1'b1, 20'h16256);

      // Test 4: Start mid-conversion ignored, operand change ignored
      @(negedge Clk);
      applyStimulus(16'h0015);
      waitDone(5, 16'hFFFF, lat, busyN);
      Start = 1'b0;
      checkOutput("t4_lat", 32'(lat), 32'd17);
      checkOutput("t4_neg", 32'(Neg), 32'd0);
      checkOutput("t4_digits", 32'(Digits), 32'h00021);
      doneCount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge Clk);
         #1 if (Done) doneCount++;
      end
      checkOutput("t4_no_second_done", 32'(doneCount), 32'd0);
      checkOutput("t4_idle_after", 32'(Busy), 32'd0);

      // Test 5: async reset aborts a running conversion
      convert("t5a", 16'h0015, 1'b0, 20'h00021);
      applyStimulus(16'h0064);
      for (int i = 1; i < 8; i++) @(posedge Clk);
      #3 Reset = 1'b0;
      #1;
      checkOutput("t5_rst_busy", 32'(Busy), 32'd0);
      checkOutput("t5_rst_done", 32'(Done), 32'd0);
      checkOutput("t5_rst_neg", 32'(Neg), 32'd0);
      checkOutput("t5_rst_digits", 32'(Digits), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      convert("t5b", 16'h0000, 1'b0, 20'h00000);

      // Test 6: Start in the Done cycle is accepted
      convert("t6a", 16'h8001, 1'b1, 20'h32767);
      checkOutput("t6_done_high", 32'(Done), 32'd1);
      applyStimulus(16'h03E8);
      checkOutput("t6_accepted_busy", 32'(Busy), 32'd1);
      waitDone(0, 16'h0, lat, busyN);
      checkOutput("t6_lat", 32'(lat), 32'd17);
      checkOutput("t6_neg", 32'(Neg), 32'd0);
      checkOutput("t6_digits", 32'(Digits), 32'h01000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
